rst_seq_mgr: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/rst_seq_mgr_sync_bit.sv | 24 ++
 rtl/rst_seq_mgr.sv | 135 +++++++++++++
 tb/tb_rst_seq_mgr.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Holds the FSM state encoding, the statistics width and the counter sizing function.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4
    } state_t;

    localparam int LOSS_CNT_W = 8;

    // One spare bit above the largest terminal count so the counter never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_seq_mgr_sync_bit.sv
// Multi-stage single-bit synchroniser with asynchronous active-high reset to 0.
// Ports: clk_i clock, rst_i async reset, d_i async input, q_o synchronised output.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/rst_seq_mgr.sv
// Reset sequencer: filters PLL lock, releases domain resets in staggered order,
// re-asserts all of them on lock loss or soft request, and tracks lock-loss statistics.
// Ports: clk, rst (async high), pll_lock (async), soft_rst_req, clr_sticky,
//        rst_n_out[N], all_ready, state_o, lock_lost_sticky, lock_loss_cnt.
module rst_seq_mgr
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS        = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_FILTER_CYCLES = 16,
    parameter int STAGGER_CYCLES     = 8,
    parameter int HOLD_CYCLES        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock,
    input  logic                   soft_rst_req,
    input  logic                   clr_sticky,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   all_ready,
    output logic [2:0]             state_o,
    output logic                   lock_lost_sticky,
    output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

    localparam int CNT_W = cnt_width(LOCK_FILTER_CYCLES, STAGGER_CYCLES, HOLD_CYCLES);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               lock_s;
    logic               active;
    logic               lock_loss;
    logic               fault;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    // Faults are only honoured once domains may be out of reset.
    always_comb begin
        active    = (state_q == RELEASE) || (state_q == RUN);
        lock_loss = active && !lock_s;
        fault     = active && (!lock_s || soft_rst_req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= WAIT_LOCK;
            cnt_q            <= '0;
            idx_q            <= '0;
            rst_n_out        <= '0;
            all_ready        <= 1'b0;
            lock_lost_sticky <= 1'b0;
            lock_loss_cnt    <= '0;
        end else begin
            // A loss in the same cycle as a clear keeps the flag set.
            if (lock_loss) begin
                lock_lost_sticky <= 1'b1;
                if (lock_loss_cnt != '1) begin
                    lock_loss_cnt <= lock_loss_cnt + 1'b1;
                end
            end else if (clr_sticky) begin
                lock_lost_sticky <= 1'b0;
            end

            if (fault) begin
                rst_n_out <= '0;
                all_ready <= 1'b0;
                cnt_q     <= '0;
                state_q   <= HOLD;
            end else begin
                unique case (state_q)
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            cnt_q   <= '0;
                            state_q <= FILTER;
                        end
                    end
                    FILTER: begin
                        if (!lock_s) begin
                            state_q <= WAIT_LOCK;
                        end else if (cnt_q == FILT_LAST) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= RELEASE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (cnt_q == STAG_LAST) begin
                            rst_n_out[idx_q] <= 1'b1;
                            cnt_q            <= '0;
                            idx_q            <= idx_q + 1'b1;
                            if (idx_q == IDX_LAST) begin
                                all_ready <= 1'b1;
                                state_q   <= RUN;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RUN: begin
                    end
                    HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            cnt_q   <= '0;
                            state_q <= WAIT_LOCK;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= WAIT_LOCK;
                    end
                endcase
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_rst_seq_mgr.sv
// Directed self-checking bench for rst_seq_mgr with default parameters.
// Drives inputs 1 time unit after each rising edge and samples there too.
module tb_rst_seq_mgr;
    import rst_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       clr_sticky;
    logic [3:0] rst_n_out;
    logic       all_ready;
    logic [2:0] state_o;
    logic       lock_lost_sticky;
    logic [7:0] lock_loss_cnt;

    int n_cmp;
    int n_fail;

    rst_seq_mgr #(
        .NUM_DOMAINS        (4),
        .SYNC_STAGES        (2),
        .LOCK_FILTER_CYCLES (16),
        .STAGGER_CYCLES     (8),
        .HOLD_CYCLES        (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pll_lock         (pll_lock),
        .soft_rst_req     (soft_rst_req),
        .clr_sticky       (clr_sticky),
        .rst_n_out        (rst_n_out),
        .all_ready        (all_ready),
        .state_o          (state_o),
        .lock_lost_sticky (lock_lost_sticky),
        .lock_loss_cnt    (lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] tgt, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state_o == tgt) break;
            tick(1);
        end
        chk(tag, 32'(state_o), 32'(tgt));
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        clr_sticky   = 1'b0;

        // Reset values
        tick(3);
        chk("rst_rst_n", 32'(rst_n_out), 32'h0);
        chk("rst_ready", 32'(all_ready), 32'h0);
        chk("rst_state", 32'(state_o), 32'(WAIT_LOCK));
        chk("rst_sticky", 32'(lock_lost_sticky), 32'h0);
        chk("rst_cnt", 32'(lock_loss_cnt), 32'h0);

        // Clean lock: lock_s high after 2 edges, T = 3rd edge, domain 0 at T+24
        pll_lock = 1'b1;
        rst      = 1'b0;
        tick(26);
        chk("clean_pre0", 32'(rst_n_out), 32'h0);
        chk("clean_rel_state", 32'(state_o), 32'(RELEASE));
        tick(1);
        chk("clean_d0", 32'(rst_n_out), 32'h1);
        tick(7);
        chk("clean_pre1", 32'(rst_n_out), 32'h1);
        tick(1);
        chk("clean_d1", 32'(rst_n_out), 32'h3);
        tick(8);
        chk("clean_d2", 32'(rst_n_out), 32'h7);
        tick(7);
        chk("clean_pre3_ready", 32'(all_ready), 32'h0);
        tick(1);
        chk("clean_d3", 32'(rst_n_out), 32'hf);
        chk("clean_ready", 32'(all_ready), 32'h1);
        chk("clean_run", 32'(state_o), 32'(RUN));
        chk("clean_cnt", 32'(lock_loss_cnt), 32'h0);

        // Lock loss in RUN: 2 sync edges, fault on the 3rd
        pll_lock = 1'b0;
        tick(2);
        chk("loss_still_run", 32'(rst_n_out), 32'hf);
        tick(1);
        chk("loss_rst_n", 32'(rst_n_out), 32'h0);
        chk("loss_ready", 32'(all_ready), 32'h0);
        chk("loss_state", 32'(state_o), 32'(HOLD));
        chk("loss_sticky", 32'(lock_lost_sticky), 32'h1);
        chk("loss_cnt", 32'(lock_loss_cnt), 32'h1);
        pll_lock = 1'b1;
        tick(31);
        chk("hold_31", 32'(state_o), 32'(HOLD));
        tick(1);
        chk("hold_end", 32'(state_o), 32'(WAIT_LOCK));
        tick(1);
        chk("relock_filter", 32'(state_o), 32'(FILTER));
        tick(23);
        chk("relock_pre0", 32'(rst_n_out), 32'h0);
        tick(1);
        chk("relock_d0", 32'(rst_n_out), 32'h1);
        tick(24);
        chk("relock_d3", 32'(rst_n_out), 32'hf);
        chk("relock_ready", 32'(all_ready), 32'h1);

        // Soft reset alone in RUN
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        chk("soft_state", 32'(state_o), 32'(HOLD));
        chk("soft_rst_n", 32'(rst_n_out), 32'h0);
        chk("soft_cnt", 32'(lock_loss_cnt), 32'h1);
        wait_state("soft_back_run", RUN, 200);

        // Soft reset coincident with lock loss
        pll_lock = 1'b0;
        tick(2);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        chk("both_state", 32'(state_o), 32'(HOLD));
        chk("both_cnt", 32'(lock_loss_cnt), 32'h2);
        pll_lock = 1'b1;
        tick(1);
        chk("both_cnt_once", 32'(lock_loss_cnt), 32'h2);
        wait_state("both_back_run", RUN, 200);

        // Glitch during FILTER restarts the filter without counting
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        wait_state("glitch_filter", FILTER, 100);
        tick(8);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(2);
        chk("glitch_wait", 32'(state_o), 32'(WAIT_LOCK));
        chk("glitch_rst_n", 32'(rst_n_out), 32'h0);
        chk("glitch_cnt", 32'(lock_loss_cnt), 32'h2);
        tick(1);
        chk("glitch_refilter", 32'(state_o), 32'(FILTER));
        tick(23);
        chk("glitch_pre0", 32'(rst_n_out), 32'h0);
        tick(1);
        chk("glitch_d0", 32'(rst_n_out), 32'h1);
        tick(8);
        chk("midrel_d1", 32'(rst_n_out), 32'h3);

        // Async reset mid-RELEASE, checked away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_n", 32'(rst_n_out), 32'h0);
        chk("async_state", 32'(state_o), 32'(WAIT_LOCK));
        chk("async_cnt", 32'(lock_loss_cnt), 32'h0);
        chk("async_sticky", 32'(lock_lost_sticky), 32'h0);
        chk("async_ready", 32'(all_ready), 32'h0);
        tick(1);
        rst = 1'b0;

        // 300 lock losses in RELEASE; the last with clr_sticky held through the fault
        for (int k = 0; k < 300; k++) begin
            wait_state("sat_rel", RELEASE, 100);
            if (k == 299) clr_sticky = 1'b1;
            pll_lock = 1'b0;
            wait_state("sat_hold", HOLD, 10);
            clr_sticky = 1'b0;
            pll_lock   = 1'b1;
            if (k == 253) chk("sat_254", 32'(lock_loss_cnt), 32'd254);
        end
        chk("sat_255", 32'(lock_loss_cnt), 32'd255);
        chk("clr_coinc_sticky", 32'(lock_lost_sticky), 32'h1);
        clr_sticky = 1'b1;
        tick(1);
        clr_sticky = 1'b0;
        chk("clr_alone_sticky", 32'(lock_lost_sticky), 32'h0);
        chk("clr_keeps_cnt", 32'(lock_loss_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
